// File: rtl/clk_div_monitor.sv
// Receiving-end checker for a divided clock: synchronises slow_in, strobes its edges,
// measures each half-period in clk cycles and tracks lock / loss against EXP_HALF.
module clk_div_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int EXP_HALF    = 400,
  parameter int TOL         = 4,
  parameter int LOCK_N      = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             slow_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost,
  output logic [7:0]       err_count
);

  localparam int GC_W = $clog2(LOCK_N + 1);

  localparam logic [1:0] S_SEEK   = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;
  localparam logic [1:0] S_LOST   = 2'd3;

  localparam logic [CNT_W-1:0] HALF_LO     = CNT_W'(EXP_HALF - TOL);
  localparam logic [CNT_W-1:0] HALF_HI     = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [GC_W-1:0]  GC_LAST     = GC_W'(LOCK_N - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [1:0]             state_reg;
  logic [1:0]             state_next;
  logic [GC_W-1:0]        good_cnt_reg;
  logic [GC_W-1:0]        good_cnt_next;
  logic [7:0]             err_count_next;

  logic s_sync;
  logic rise_det;
  logic fall_det;
  logic edge_det;
  logic good;
  logic timeout;
  logic measuring;

  assign s_sync    = sync_reg[SYNC_STAGES-1];
  assign rise_det  = s_sync & ~prev_reg;
  assign fall_det  = ~s_sync & prev_reg;
  assign edge_det  = rise_det | fall_det;
  assign good      = (cnt_reg >= HALF_LO) && (cnt_reg <= HALF_HI);
  // An edge landing on the timeout cycle takes priority over declaring loss.
  assign timeout   = !edge_det && (cnt_reg == TIMEOUT_CNT);
  assign measuring = edge_det && ((state_reg == S_TRACK) || (state_reg == S_LOCKED));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], slow_in};
      prev_reg <= s_sync;
    end
  end

  // Edge-to-edge interval; the value seen on an edge cycle is the elapsed clk count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg <= '0;
    end else if (edge_det) begin
      cnt_reg <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (cnt_reg != {CNT_W{1'b1}}) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next     = state_reg;
    good_cnt_next  = good_cnt_reg;
    err_count_next = err_count;
    case (state_reg)
      S_SEEK, S_LOST: begin
        if (edge_det) begin
          state_next    = S_TRACK;
          good_cnt_next = '0;
        end
      end
      S_TRACK: begin
        if (edge_det) begin
          if (!good) begin
            good_cnt_next = '0;
          end else if (good_cnt_reg == GC_LAST) begin
            state_next    = S_LOCKED;
            good_cnt_next = '0;
          end else begin
            good_cnt_next = good_cnt_reg + 1'b1;
          end
        end else if (timeout) begin
          state_next = S_LOST;
        end
      end
      default: begin
        if (edge_det) begin
          if (!good) begin
            state_next    = S_TRACK;
            good_cnt_next = '0;
            if (err_count != 8'hFF) begin
              err_count_next = err_count + 8'd1;
            end
          end
        end else if (timeout) begin
          state_next = S_LOST;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= S_SEEK;
      good_cnt_reg <= '0;
      err_count    <= 8'd0;
    end else begin
      state_reg    <= state_next;
      good_cnt_reg <= good_cnt_next;
      err_count    <= err_count_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      period_valid <= 1'b0;
      half_period  <= '0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else begin
      rise_pulse   <= rise_det;
      fall_pulse   <= fall_det;
      period_valid <= measuring;
      if (measuring) begin
        half_period <= cnt_reg;
      end
      locked       <= (state_next == S_LOCKED);
      lost         <= (state_next == S_LOST);
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: an edge-list model predicts every output each cycle,
// and literal checks pin latency, lock, error, timeout and reset behaviour.
module tb_clk_div_monitor;

  localparam int SYNC     = 2;
  localparam int EXP_HALF = 400;
  localparam int TOL      = 4;
  localparam int LOCK_N   = 4;
  localparam int TIMEOUT  = 1024;

  logic        clk = 1'b0;
  logic        resetn;
  logic        slow_in;
  logic        rise_pulse;
  logic        fall_pulse;
  logic [15:0] half_period;
  logic        period_valid;
  logic        locked;
  logic        lost;
  logic [7:0]  err_count;

  clk_div_monitor #(
    .SYNC_STAGES(SYNC), .CNT_W(16), .EXP_HALF(EXP_HALF),
    .TOL(TOL), .LOCK_N(LOCK_N), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn), .slow_in(slow_in),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .half_period(half_period), .period_valid(period_valid),
    .locked(locked), .lost(lost), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int fail_prints = 0;

  // Behavioural model: edges are seen SYNC+1 samples after slow_in changes.
  typedef enum int {M_SEEK, M_TRACK, M_LOCKED, M_LOST} mstate_t;
  mstate_t         m_state   = M_SEEK;
  logic [SYNC+1:0] samp      = '0;
  int              cyc       = 0;
  int              m_last    = 0;
  int              m_gc      = 0;
  int              m_err     = 0;
  int              m_half    = 0;
  logic            exp_rise  = 1'b0;
  logic            exp_fall  = 1'b0;
  logic            exp_pv    = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        samp = '0; m_state = M_SEEK; m_gc = 0; m_err = 0; m_half = 0;
        exp_rise = 1'b0; exp_fall = 1'b0; exp_pv = 1'b0; m_last = cyc;
      end else begin
        int ivl;
        cyc++;
        samp     = {samp[SYNC:0], slow_in};
        exp_rise = samp[SYNC] & ~samp[SYNC+1];
        exp_fall = ~samp[SYNC] & samp[SYNC+1];
        exp_pv   = 1'b0;
        ivl      = cyc - m_last;
        if (ivl > 65535) ivl = 65535;
        if (exp_rise || exp_fall) begin
          if (m_state == M_SEEK || m_state == M_LOST) begin
            m_state = M_TRACK; m_gc = 0;
          end else begin
            bit is_good;
            is_good = (ivl >= EXP_HALF - TOL) && (ivl <= EXP_HALF + TOL);
            exp_pv  = 1'b1;
            m_half  = ivl;
            if (m_state == M_TRACK) begin
              m_gc = is_good ? m_gc + 1 : 0;
              if (m_gc == LOCK_N) begin m_state = M_LOCKED; m_gc = 0; end
            end else if (!is_good) begin
              m_state = M_TRACK; m_gc = 0;
              if (m_err < 255) m_err++;
            end
          end
          m_last = cyc;
        end else if ((m_state == M_TRACK || m_state == M_LOCKED) && ivl == TIMEOUT) begin
          m_state = M_LOST;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    if (act !== expv) begin
      miscompares++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
      end
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    cmp(name, act, expv);
  endtask

  // Per-cycle compare plus event capture for the literal checks.
  int   edge_cyc = 0, tog_cyc = 0, last_lat = 0, lost_cyc = 0, pv_count = 0;
  logic lost_q = 1'b0, lost_seen = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      vectors++;
      cmp("rise_pulse",   32'(rise_pulse),   32'(exp_rise));
      cmp("fall_pulse",   32'(fall_pulse),   32'(exp_fall));
      cmp("period_valid", 32'(period_valid), 32'(exp_pv));
      cmp("half_period",  32'(half_period),  32'(m_half));
      cmp("locked",       32'(locked),       32'(m_state == M_LOCKED));
      cmp("lost",         32'(lost),         32'(m_state == M_LOST));
      cmp("err_count",    32'(err_count),    32'(m_err));
      if (rise_pulse || fall_pulse) begin
        edge_cyc = cyc;
        last_lat = cyc - tog_cyc;
      end
      if (period_valid) pv_count++;
      if (lost && !lost_q) lost_cyc = cyc;
      if (lost) lost_seen = 1'b1;
      lost_q = lost;
    end
  end

  // Toggle slow_in, then hold it for n clk cycles; called 3 ns after a posedge.
  task automatic half(input int n);
    slow_in = ~slow_in;
    tog_cyc = cyc;
    $display("cycle %0d: slow_in -> %0b, hold %0d clk (half_period=%0d locked=%0b lost=%0b err=%0d)",
             cyc, slow_in, n, half_period, locked, lost, err_count);
    repeat (n) @(posedge clk);
    #3;
  endtask

  int pv_mark;

  initial begin
    resetn  = 1'b0;
    slow_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_lit("reset_outputs",
              32'({rise_pulse, fall_pulse, period_valid, locked, lost, half_period, err_count}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(posedge clk);
    #3;

    // Nominal 400-cycle halves: first edge discarded, lock after the 4th good one.
    repeat (6) half(400);
    check_lit("t1_latency",  32'(last_lat), 32'd3);
    check_lit("t1_pv_count", 32'(pv_count), 32'd5);
    check_lit("t1_half",     32'(half_period), 32'd400);
    check_lit("t1_locked",   32'(locked), 32'd1);
    check_lit("t1_model",    32'(m_state == M_LOCKED), 32'd1);

    // One 410 half while locked: lock drops, one error, relock after 4 good halves.
    half(410);
    half(400);
    check_lit("t2_half",   32'(half_period), 32'd410);
    check_lit("t2_locked", 32'(locked), 32'd0);
    check_lit("t2_err",    32'(err_count), 32'd1);
    check_lit("t2_model_err", 32'(m_err), 32'd1);
    repeat (4) half(400);
    check_lit("t2_relock", 32'(locked), 32'd1);

    // Tolerance edges: 395/405 are bad, 396/404 are good.
    half(395);
    half(405);
    half(396);
    check_lit("t3_unlocked", 32'(locked), 32'd0);
    check_lit("t3_err",      32'(err_count), 32'd2);
    check_lit("t3_half_405", 32'(half_period), 32'd405);
    half(404);
    half(396);
    half(404);
    check_lit("t3_not_yet",  32'(locked), 32'd0);
    half(400);
    check_lit("t3_locked",   32'(locked), 32'd1);
    check_lit("t3_half_404", 32'(half_period), 32'd404);

    // Stop toggling: LOST exactly TIMEOUT cycles after the last edge strobe.
    repeat (700) @(posedge clk);
    #3;
    check_lit("t4_lost",      32'(lost), 32'd1);
    check_lit("t4_locked",    32'(locked), 32'd0);
    check_lit("t4_lost_time", 32'(lost_cyc - edge_cyc), 32'd1024);
    check_lit("t4_half_hold", 32'(half_period), 32'd404);
    pv_mark = pv_count;
    half(1024);
    check_lit("t4_recover",   32'(lost), 32'd0);
    check_lit("t4_no_pv",     32'(pv_count - pv_mark), 32'd0);

    // Edge on the exact timeout cycle wins.
    lost_seen = 1'b0;
    half(20);
    check_lit("t5_no_lost",   32'(lost_seen), 32'd0);
    check_lit("t5_half",      32'(half_period), 32'd1024);
    check_lit("t5_model",     32'(m_state == M_TRACK), 32'd1);

    // Relock, then async reset mid-lock.
    repeat (6) half(400);
    check_lit("t6_locked",    32'(locked), 32'd1);
    @(negedge clk);
    #2;
    resetn  = 1'b0;
    slow_in = 1'b0;
    #1;
    check_lit("t6_async_reset",
              32'({rise_pulse, fall_pulse, period_valid, locked, lost, half_period, err_count}), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    resetn    = 1'b1;
    lost_seen = 1'b0;
    repeat (2000) @(posedge clk);
    #3;
    check_lit("t6_static_no_lost", 32'(lost_seen), 32'd0);
    pv_mark = pv_count;
    half(400);
    check_lit("t6_first_discard", 32'(half_period), 32'd0);
    check_lit("t6_first_no_pv",   32'(pv_count - pv_mark), 32'd0);
    half(400);
    check_lit("t6_second_half",   32'(half_period), 32'd400);

    repeat (5) @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
